// File: rtl/popcount_seq_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// popcount_seq_unit_if : input/result handshake bundle for popcount_seq_unit
// Optional out_parity signal present when POPCOUNT_PARITY_EN is defined.
// Revision: 1.0
// ----------------------------------------------------------------------------
interface popcount_seq_unit_if #(
  parameter int WIDTH = 32
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
`ifdef POPCOUNT_PARITY_EN
  logic             out_parity;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_count, out_parity
  );
  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_count, out_parity
  );
`else
  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_count
  );
  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_count
  );
`endif
endinterface
`default_nettype wire

// File: rtl/popcount_seq_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// popcount_seq_unit : multi-cycle ones/zeros counter, CHUNK bits per clock
// Optional parity output enabled by defining POPCOUNT_PARITY_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module popcount_seq_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  popcount_seq_unit_if.slave bus
);
  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d, data_shift;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic [CNT_W-1:0] chunk_cnt, sum;
`ifdef POPCOUNT_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // The working word is shifted down so the active chunk is always at bit 0.
  generate
    if (N > 1) begin : g_shift
      assign data_shift = {{CHUNK{1'b0}}, data_q[WIDTH-1:CHUNK]};
    end else begin : g_noshift
      assign data_shift = data_q;
    end
  endgenerate

  always_comb begin
    chunk_cnt = '0;
    for (int b = 0; b < CHUNK; b++) begin
      chunk_cnt = chunk_cnt + CNT_W'(data_q[b]);
    end
  end

  assign sum = acc_q + chunk_cnt;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
`ifdef POPCOUNT_PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.in_mode ? ~bus.in_data : bus.in_data;
          acc_d   = '0;
          idx_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        data_d = data_shift;
        acc_d  = sum;
        idx_d  = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          out_count_d = sum;
          out_valid_d = 1'b1;
`ifdef POPCOUNT_PARITY_EN
          parity_d    = sum[0];
`endif
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
`ifdef POPCOUNT_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
`ifdef POPCOUNT_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_count = out_count_q;
`ifdef POPCOUNT_PARITY_EN
  assign bus.out_parity = parity_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_popcount_seq_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_popcount_seq_unit : scoreboard bench for popcount_seq_unit
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_popcount_seq_unit;
  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  popcount_seq_unit_if #(.WIDTH(WIDTH)) bus ();

  popcount_seq_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int chk = 0;
  int err = 0;
  int cyc = 0;
  int bp_mode = 0;  // 0: always ready, 1: random, 2: held low

  logic [CNT_W:0]   exp_q[$];   // {parity, count}
  int               acc_edge_q[$];
  logic [CNT_W-1:0] held_cnt;
  logic             prev_valid;
  logic             prev_xfer;

  task automatic check(input string name, input int act, input int exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  end

  // Monitor: scoreboard on accepts, compares on each result transfer.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_edge_q.delete();
      prev_valid = 1'b0;
      prev_xfer  = 1'b0;
    end else begin
      if (prev_xfer) check("valid_one_cycle", int'(bus.out_valid), 0);
      if (bus.out_valid && !prev_valid) begin
        if (acc_edge_q.size() == 0) check("unexpected_result", 1, 0);
        else check("latency", cyc - acc_edge_q.pop_front(), N);
        held_cnt = bus.out_count;
      end
      if (bus.out_valid) begin
        check("in_ready_busy", int'(bus.in_ready), 0);
        if (!bus.out_ready) check("stall_hold", int'(bus.out_count), int'(held_cnt));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("unexpected_xfer", 1, 0);
        else begin
          logic [CNT_W:0] e;
          e = exp_q.pop_front();
          check("count", int'(bus.out_count), int'(e[CNT_W-1:0]));
`ifdef POPCOUNT_PARITY_EN
          check("parity", int'(bus.out_parity), int'(e[CNT_W]));
`endif
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        logic [WIDTH-1:0] w;
        w = bus.in_mode ? ~bus.in_data : bus.in_data;
        exp_q.push_back({^w, CNT_W'($countones(w))});
        acc_edge_q.push_back(cyc + 1);
      end
      prev_valid = bus.out_valid;
      prev_xfer  = bus.out_valid && bus.out_ready;
    end
  end

  task automatic send(input logic [WIDTH-1:0] d, input logic m);
    int t = 0;
    while (!bus.in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.in_ready) begin
      check("send_timeout", 1, 0);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_mode  = m;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    bus.in_mode  = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_count", int'(bus.out_count), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
`ifdef POPCOUNT_PARITY_EN
    check("rst_out_parity", int'(bus.out_parity), 0);
`endif
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_mode  = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    send(32'hAAAA_AAAA, 1'b0);
    send(32'hFFFF_FFFF, 1'b0);
    send(32'h0000_00FF, 1'b1);
    send(32'h0000_0000, 1'b0);
    send(32'h0000_0000, 1'b1);
    send(32'h0000_0007, 1'b0);
    send(32'h0000_0003, 1'b0);
    drain();

    // Backpressure window with an ignored in_valid pulse.
    bp_mode = 2;
    send(32'h1234_5678, 1'b0);
    begin
      int t = 0;
      while (!bus.out_valid && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
    end
    check("stall_valid_seen", int'(bus.out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i == 2);
      bus.in_data  = 32'hFFFF_FFFF;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("stall_valid_held", int'(bus.out_valid), 1);
    bp_mode = 0;
    drain();

    // Abort mid-count.
    send(32'hFFFF_0000, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    send(32'h0000_0001, 1'b0);
    drain();

    // Randomized traffic with random backpressure.
    bp_mode = 1;
    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] d;
      case ($urandom_range(0, 4))
        0:       d = '1;
        1:       d = '0;
        default: d = $urandom;
      endcase
      send(d, 1'($urandom_range(0, 1)));
    end
    bp_mode = 0;
    drain();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
